// File: rtl/imm_pkg.sv
// Shared opcode and immediate-format definitions
// for the immediate decode stage.
package imm_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_SLLI = 3'b001;
    localparam logic [2:0] F3_SRXI = 3'b101;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_SH  = 3'd6,
        FMT_ILL = 3'd7
    } fmt_t;

    localparam int ILL_W = 16;

endpackage

// File: rtl/imm_decode_core.sv
// Combinational RV32I immediate extractor:
// instruction word in, XLEN immediate and format code out.
module imm_decode_core
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     ins,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt
);

    logic [6:0]  w_op;
    logic [2:0]  w_f3;
    logic [31:0] w_shamt;
    logic [31:0] w_imm32;

    assign w_op = ins[6:0];
    assign w_f3 = ins[14:12];

    // RV64 shifts use a 6-bit shamt; funct7 bits never leak in
    assign w_shamt = (XLEN == 64) ? {26'd0, ins[25:20]}
                                  : {27'd0, ins[24:20]};

    // Select format and assemble a 32-bit sign-correct immediate
    always_comb begin
        w_imm32 = '0;
        fmt     = FMT_ILL;
        case (w_op)
            OP_IMM: begin
                if (w_f3 == F3_SLLI || w_f3 == F3_SRXI) begin
                    fmt     = FMT_SH;
                    w_imm32 = w_shamt;
                end else begin
                    fmt     = FMT_I;
                    w_imm32 = {{20{ins[31]}}, ins[31:20]};
                end
            end
            OP_LOAD, OP_JALR: begin
                fmt     = FMT_I;
                w_imm32 = {{20{ins[31]}}, ins[31:20]};
            end
            OP_STORE: begin
                fmt     = FMT_S;
                w_imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            OP_BRANCH: begin
                fmt     = FMT_B;
                w_imm32 = {{19{ins[31]}}, ins[31], ins[7],
                           ins[30:25], ins[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt     = FMT_U;
                w_imm32 = {ins[31:12], 12'd0};
            end
            OP_JAL: begin
                fmt     = FMT_J;
                w_imm32 = {{11{ins[31]}}, ins[31], ins[19:12],
                           ins[20], ins[30:21], 1'b0};
            end
            OP_REG: begin
                fmt     = FMT_R;
                w_imm32 = '0;
            end
            default: begin
                fmt     = FMT_ILL;
                w_imm32 = '0;
            end
        endcase
    end

    // Shift amounts have bit 31 clear, so this is a zero-extend for them
    assign imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode stage: decodes on transfer and queues
// {imm, fmt, tag} in a small FIFO; counts illegal opcodes.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_ins,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag,
    output logic [15:0]      ill_count
);

    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0]  r_imm [DEPTH];
    logic [2:0]       r_fmt [DEPTH];
    logic [TAG_W-1:0] r_tag [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [15:0]      r_ill;

    logic [XLEN-1:0]  w_imm;
    logic [2:0]       w_fmt;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;

    imm_decode_core #(
        .XLEN (XLEN)
    ) u_core (
        .ins (in_ins),
        .imm (w_imm),
        .fmt (w_fmt)
    );

    assign w_wr_idx = r_wr_ptr[AW-1:0];
    assign w_rd_idx = r_rd_ptr[AW-1:0];
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (w_wr_idx == w_rd_idx);

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Empty buffer presents zeros so reset/flush outputs are clean
    assign out_imm = w_empty ? '0 : r_imm[w_rd_idx];
    assign out_fmt = w_empty ? '0 : r_fmt[w_rd_idx];
    assign out_tag = w_empty ? '0 : r_tag[w_rd_idx];

    assign ill_count = r_ill;

    // Entry storage: written only on an accepted, non-flushed push
    always_ff @(posedge clk) begin
        if (!rst && !flush && w_push) begin
            r_imm[w_wr_idx] <= w_imm;
            r_fmt[w_wr_idx] <= w_fmt;
            r_tag[w_wr_idx] <= in_tag;
        end
    end

    // Pointer update; flush drops the buffer and any same-cycle push
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Saturating illegal-opcode counter; flush does not mask transfers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ill <= '0;
        end else if (w_push && w_fmt == FMT_ILL && r_ill != 16'hFFFF) begin
            r_ill <= r_ill + 16'd1;
        end
    end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed testbench for imm_decode_stage (XLEN 32 and 64 instances).
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_ins;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic [7:0]  out_tag;
    logic [15:0] ill_count;

    logic        rst64;
    logic        flush64;
    logic        in_valid64;
    logic        in_ready64;
    logic [31:0] in_ins64;
    logic [7:0]  in_tag64;
    logic        out_valid64;
    logic        out_ready64;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt64;
    logic [7:0]  out_tag64;
    logic [15:0] ill_count64;

    int checks = 0;
    int errors = 0;
    int exp_ill = 0;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .DEPTH(2), .TAG_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ins    (in_ins),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_fmt   (out_fmt),
        .out_tag   (out_tag),
        .ill_count (ill_count)
    );

    imm_decode_stage #(.XLEN(64), .DEPTH(2), .TAG_W(8)) dut64 (
        .clk       (clk),
        .rst       (rst64),
        .flush     (flush64),
        .in_valid  (in_valid64),
        .in_ready  (in_ready64),
        .in_ins    (in_ins64),
        .in_tag    (in_tag64),
        .out_valid (out_valid64),
        .out_ready (out_ready64),
        .out_imm   (out_imm64),
        .out_fmt   (out_fmt64),
        .out_tag   (out_tag64),
        .ill_count (ill_count64)
    );

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_ins = 32'h0; in_tag = 8'h0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ill_count !== 16'h0 ||
            out_imm !== 32'h0 || out_fmt !== 3'd0 || out_tag !== 8'h0) begin
            errors++;
            $display("FAIL reset: v=%b r=%b ill=%h imm=%h fmt=%0d tag=%h want 0 1 0 0 0 0",
                     out_valid, in_ready, ill_count, out_imm, out_fmt, out_tag);
        end
        exp_ill = 0;
    endtask

    task automatic test_formats();
        logic [31:0] v_ins [11];
        logic [31:0] v_imm [11];
        logic [2:0]  v_fmt [11];
        v_ins[0]  = 32'hFFF00093; v_imm[0]  = 32'hFFFFFFFF; v_fmt[0]  = 3'd1;
        v_ins[1]  = 32'hFE000EE3; v_imm[1]  = 32'hFFFFFFFC; v_fmt[1]  = 3'd3;
        v_ins[2]  = 32'h0080006F; v_imm[2]  = 32'h00000008; v_fmt[2]  = 3'd5;
        v_ins[3]  = 32'h123450B7; v_imm[3]  = 32'h12345000; v_fmt[3]  = 3'd4;
        v_ins[4]  = 32'h4030D093; v_imm[4]  = 32'h00000003; v_fmt[4]  = 3'd6;
        v_ins[5]  = 32'hFE20AE23; v_imm[5]  = 32'hFFFFFFFC; v_fmt[5]  = 3'd2;
        v_ins[6]  = 32'h00402083; v_imm[6]  = 32'h00000004; v_fmt[6]  = 3'd1;
        v_ins[7]  = 32'h00000033; v_imm[7]  = 32'h00000000; v_fmt[7]  = 3'd0;
        v_ins[8]  = 32'h0000007F; v_imm[8]  = 32'h00000000; v_fmt[8]  = 3'd7;
        v_ins[9]  = 32'h0230D093; v_imm[9]  = 32'h00000003; v_fmt[9]  = 3'd6;
        v_ins[10] = 32'h80000067; v_imm[10] = 32'hFFFFF800; v_fmt[10] = 3'd1;
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1;
            in_ins   = v_ins[i];
            in_tag   = 8'(i + 8'h10);
            @(posedge clk);
            #1 in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_imm !== v_imm[i] ||
                out_fmt !== v_fmt[i] || out_tag !== 8'(i + 8'h10)) begin
                errors++;
                $display("FAIL fmt[%0d] ins=%h: v=%b imm=%h fmt=%0d tag=%h want 1 %h %0d %h",
                         i, v_ins[i], out_valid, out_imm, out_fmt, out_tag,
                         v_imm[i], v_fmt[i], 8'(i + 8'h10));
            end
        end
        exp_ill = 1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || ill_count !== 16'(exp_ill)) begin
            errors++;
            $display("FAIL fmt_drain: v=%b ill=%0d want 0 %0d",
                     out_valid, ill_count, exp_ill);
        end
    endtask

    task automatic test_xlen64();
        rst64 = 1'b1; flush64 = 1'b0; in_valid64 = 1'b0;
        in_ins64 = 32'h0; in_tag64 = 8'h0; out_ready64 = 1'b1;
        @(posedge clk);
        #1 rst64 = 1'b0;
        in_valid64 = 1'b1; in_ins64 = 32'hFFF00093; in_tag64 = 8'hA1;
        @(posedge clk);
        #1 in_ins64 = 32'h0230D093; in_tag64 = 8'hA2;
        @(negedge clk);
        checks++;
        if (out_valid64 !== 1'b1 || out_imm64 !== 64'hFFFFFFFFFFFFFFFF ||
            out_fmt64 !== 3'd1) begin
            errors++;
            $display("FAIL x64_addi: v=%b imm=%h fmt=%0d want 1 ffffffffffffffff 1",
                     out_valid64, out_imm64, out_fmt64);
        end
        @(posedge clk);
        #1 in_ins64 = 32'hFE000EE3;
        @(negedge clk);
        checks++;
        if (out_imm64 !== 64'd35 || out_fmt64 !== 3'd6) begin
            errors++;
            $display("FAIL x64_shamt: imm=%h fmt=%0d want 23 6", out_imm64, out_fmt64);
        end
        @(posedge clk);
        #1 in_valid64 = 1'b0;
        @(negedge clk);
        checks++;
        if (out_imm64 !== 64'hFFFFFFFFFFFFFFFC || out_fmt64 !== 3'd3) begin
            errors++;
            $display("FAIL x64_branch: imm=%h fmt=%0d want fffffffffffffffc 3",
                     out_imm64, out_fmt64);
        end
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ins    = 32'h00000033;
        in_tag    = 8'd1;
        @(posedge clk);
        #1 in_tag = 8'd2;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_tag !== 8'd1) begin
            errors++;
            $display("FAIL full_one: rdy=%b tag=%0d want 1 1", in_ready, out_tag);
        end
        @(posedge clk);
        #1 in_tag = 8'd3;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_two: rdy=%b want 0", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 8'd1) begin
            errors++;
            $display("FAIL full_hold: rdy=%b v=%b tag=%0d want 0 1 1",
                     in_ready, out_valid, out_tag);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_tag !== 8'd2) begin
            errors++;
            $display("FAIL full_pop: rdy=%b tag=%0d want 1 2", in_ready, out_tag);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 8'd3) begin
            errors++;
            $display("FAIL full_order: v=%b tag=%0d want 1 3", out_valid, out_tag);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_drain: v=%b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ins    = 32'h0000007F;
        in_tag    = 8'h55;
        repeat (2) @(posedge clk);
        exp_ill = exp_ill + 2;
        #1 flush = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || ill_count !== 16'(exp_ill)) begin
            errors++;
            $display("FAIL flush_pre: rdy=%b ill=%0d want 0 %0d",
                     in_ready, ill_count, exp_ill);
        end
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
            ill_count !== 16'(exp_ill)) begin
            errors++;
            $display("FAIL flush_full: v=%b rdy=%b ill=%0d want 0 1 %0d",
                     out_valid, in_ready, ill_count, exp_ill);
        end
        flush = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        exp_ill = exp_ill + 1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || ill_count !== 16'(exp_ill)) begin
            errors++;
            $display("FAIL flush_xfer: v=%b ill=%0d want 0 %0d",
                     out_valid, ill_count, exp_ill);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ins    = 32'h0000007F;
        in_tag    = 8'h66;
        @(posedge clk);
        #1 rst = 1'b1; in_tag = 8'h67;
        @(posedge clk);
        #1 rst = 1'b0; in_valid = 1'b0;
        exp_ill = 0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ill_count !== 16'h0 ||
            out_imm !== 32'h0 || out_fmt !== 3'd0 || out_tag !== 8'h0) begin
            errors++;
            $display("FAIL reset_mid: v=%b r=%b ill=%h imm=%h fmt=%0d tag=%h want 0 1 0 0 0 0",
                     out_valid, in_ready, ill_count, out_imm, out_fmt, out_tag);
        end
    endtask

    task automatic test_saturate();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_ins    = 32'h0000007F;
        in_tag    = 8'h77;
        repeat (100) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ill_count !== 16'd100 || out_fmt !== 3'd7 || out_imm !== 32'h0) begin
            errors++;
            $display("FAIL sat_mid: ill=%0d fmt=%0d imm=%h want 100 7 0",
                     ill_count, out_fmt, out_imm);
        end
        repeat (69900) @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ill_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_end: ill=%h want ffff", ill_count);
        end
    endtask

    initial begin
        rst64 = 1'b1; flush64 = 1'b0; in_valid64 = 1'b0;
        in_ins64 = 32'h0; in_tag64 = 8'h0; out_ready64 = 1'b1;
        test_reset();
        test_formats();
        test_xlen64();
        test_full();
        test_flush();
        test_reset_mid();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width; legal values 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 2, output buffer entries; power of two, at least 2.
REQ-003 SHALL have parameter TAG_W, default 8, width of the sideband tag carried with each instruction.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  synchronous buffer clear.
REQ-007 in_valid  input  1  instruction offered.
REQ-008 in_ready  output  1  stage can accept.
REQ-009 in_ins  input  32  RV32I instruction word.
REQ-010 in_tag  input  TAG_W  opaque sideband, returned unchanged.
REQ-011 out_valid  output  1  buffer head valid.
REQ-012 out_ready  input  1  consumer accepts head.
REQ-013 out_imm  output  XLEN  decoded immediate.
REQ-014 out_fmt  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, SH=6, ILL=7.
REQ-015 out_tag  output  TAG_W  tag of the head entry.
REQ-016 ill_count  output  16  count of accepted illegal opcodes, saturating.

Function
REQ-017 SHALL decode on transfer (in_valid and in_ready): opcodes 0010011, 0000011 and 1100111 -> I, sign-extended ins[31:20].
REQ-018 SHALL decode opcode 0010011 with funct3 001 or 101 -> SH, zero-extended shamt: ins[24:20] when XLEN=32, ins[25:20] when XLEN=64; funct7 bits excluded.
REQ-019 SHALL decode 0100011 -> S, sign-extended {ins[31:25], ins[11:7]}.
REQ-020 SHALL decode 1100011 -> B, sign-extended {ins[31], ins[7], ins[30:25], ins[11:8], 0}.
REQ-021 SHALL decode 0110111 and 0010111 -> U, {ins[31:12], 12'b0}, sign-extended to XLEN.
REQ-022 SHALL decode 1101111 -> J, sign-extended {ins[31], ins[19:12], ins[20], ins[30:21], 0}.
REQ-023 SHALL decode 0110011 -> R with imm 0; any other opcode -> ILL with imm 0; never X.
REQ-024 SHALL write each decoded result, with its tag, into a DEPTH-entry FIFO; latency from transfer to out_valid is 1 cycle when the FIFO is empty.
REQ-025 SHALL drive in_ready = not full, combinationally from occupancy only.
REQ-026 SHALL drive out_valid = not empty, with out_imm, out_fmt and out_tag showing the head entry; the head SHALL stay stable while out_valid is high and out_ready is low.
REQ-027 SHALL, on simultaneous push and pop, leave occupancy unchanged; this SHALL be legal when empty is false.
REQ-028 SHALL, when full, deassert in_ready; a pop that cycle frees the slot for the next cycle, with no same-cycle bypass.
REQ-029 SHALL wrap read and write pointers modulo DEPTH, using an extra pointer bit to distinguish full from empty.
REQ-030 SHALL increment ill_count by 1 per accepted ILL instruction, holding at 0xFFFF.
REQ-031 SHALL, on flush, empty the FIFO next cycle, drop any same-cycle push, and leave ill_count unchanged; a flush-cycle transfer still counts toward ill_count.

Reset
REQ-032 SHALL, on rst, empty the FIFO and set out_valid=0, in_ready=1, ill_count=0, out_imm=0, out_fmt=0, out_tag=0.
REQ-033 SHALL let rst override flush and any handshake in the same cycle; a transfer during rst is discarded and not counted.

Structure
REQ-034 SHALL take opcode constants, format codes and the ILL/R code values from a shared package, imm_pkg.
REQ-035 SHALL isolate decode in one combinational sub-module, imm_decode_core (ins, xlen-parametrised imm, fmt); the top holds the FIFO and counter.

Verification
REQ-036 0xFFF00093 pushed into an empty FIFO -> next cycle out_valid=1, imm 0xFFFFFFFF, fmt 1.
REQ-037 0xFE000EE3 -> imm 0xFFFFFFFC, fmt 3; 0x0080006F -> imm 0x00000008, fmt 5; 0x123450B7 -> imm 0x12345000, fmt 4.
REQ-038 0x4030D093 -> imm 0x00000003, fmt 6; with XLEN=64, 0xFFF00093 -> imm 0xFFFFFFFFFFFFFFFF.
REQ-039 out_ready=0, 3 pushes with DEPTH=2 -> in_ready=0 after 2 pushes, 3rd not accepted; pop then push -> tags emerge in order.
REQ-040 opcode 0x7F pushed 70000 times -> fmt 7, imm 0, ill_count saturates at 0xFFFF.
REQ-041 FIFO full, flush plus push asserted together -> next cycle out_valid=0, in_ready=1, ill_count unchanged; rst mid-stream -> all outputs equal their reset values.
